// File: rtl/uart_framer_pkg.sv
// Shared constants and the TX state type for the UART word framer.
package uart_framer_pkg;

    localparam int unsigned BYTE_W                 = 8;
    localparam int unsigned DEFAULT_RX_BYTES       = 80;
    localparam int unsigned DEFAULT_TX_BYTES       = 4;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 5_000_000;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_BUSY,
        WAIT_IDLE
    } tx_state_t;

endpackage

// File: rtl/uart_tx_serializer.sv
// Sends a TX_BYTES-wide word MSB byte first, handing one byte at a time to the UART
// and waiting for each tx_busy rise and fall before moving on.
module uart_tx_serializer
    import uart_framer_pkg::*;
#(
    parameter int unsigned TX_BYTES = DEFAULT_TX_BYTES
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [TX_BYTES*BYTE_W-1:0] tx_data,
    input  logic                       tx_start,
    input  logic                       tx_busy,
    output logic                       tx_ready,
    output logic                       tx_done,
    output logic [BYTE_W-1:0]          tx_byte,
    output logic                       tx_wr_en
);

    localparam int unsigned TX_W  = TX_BYTES * BYTE_W;
    localparam int unsigned REM_W = $clog2(TX_BYTES + 1);

    tx_state_t         state_q, state_d;
    logic [TX_W-1:0]   shreg_q, shreg_d;
    logic [REM_W-1:0]  remaining_q, remaining_d;
    logic [BYTE_W-1:0] byte_q, byte_d;
    logic              wr_en_q, wr_en_d;
    logic              done_q, done_d;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        remaining_d = remaining_q;
        byte_d      = byte_q;
        wr_en_d     = 1'b0;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tx_start) begin
                    shreg_d     = tx_data;
                    remaining_d = REM_W'(TX_BYTES);
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (!tx_busy) begin
                    byte_d  = shreg_q[TX_W-1 -: BYTE_W];
                    wr_en_d = 1'b1;
                    state_d = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                // The byte counts as sent only once the UART has finished it.
                if (!tx_busy) begin
                    shreg_d     = shreg_q << BYTE_W;
                    remaining_d = remaining_q - REM_W'(1);
                    if (remaining_q == REM_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            remaining_q <= '0;
            byte_q      <= '0;
            wr_en_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            remaining_q <= remaining_d;
            byte_q      <= byte_d;
            wr_en_q     <= wr_en_d;
            done_q      <= done_d;
        end
    end

    assign tx_ready = (state_q == IDLE);
    assign tx_done  = done_q;
    assign tx_byte  = byte_q;
    assign tx_wr_en = wr_en_q;

endmodule

// File: rtl/uart_word_framer.sv
// Frames the UART byte stream for the miner: assembles RX_BYTES-byte frames with
// valid/ack, overrun and idle timeout, and serialises TX words via uart_tx_serializer.
module uart_word_framer
    import uart_framer_pkg::*;
#(
    parameter int unsigned RX_BYTES       = DEFAULT_RX_BYTES,
    parameter int unsigned TX_BYTES       = DEFAULT_TX_BYTES,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [BYTE_W-1:0]          rx_byte,
    input  logic                       rx_rdy,
    output logic                       rx_clr,
    output logic [RX_BYTES*BYTE_W-1:0] rx_data,
    output logic                       rx_valid,
    input  logic                       rx_ack,
    output logic                       rx_overrun,
    input  logic [TX_BYTES*BYTE_W-1:0] tx_data,
    input  logic                       tx_start,
    output logic                       tx_ready,
    output logic                       tx_done,
    output logic [BYTE_W-1:0]          tx_byte,
    output logic                       tx_wr_en,
    input  logic                       tx_busy
);

    localparam int unsigned RX_W  = RX_BYTES * BYTE_W;
    localparam int unsigned CNT_W = $clog2(RX_BYTES + 1);
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [RX_W-1:0]  data_q, data_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             clr_q, clr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             accept;

    // rdy is still high during the clear cycle; masking with clr_q avoids taking it twice.
    assign accept = rx_rdy && !clr_q;

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        count_d   = count_q;
        tmo_d     = tmo_q;
        clr_d     = accept;

        if (rx_ack && valid_q) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        if (accept) begin
            tmo_d = '0;
            if (valid_d) begin
                overrun_d = 1'b1;
            end else begin
                data_d = RX_W'({data_q, rx_byte});
                if (count_q == CNT_W'(RX_BYTES - 1)) begin
                    valid_d = 1'b1;
                    count_d = '0;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
        end else if (count_q == '0) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            // Stale bytes stay in data_q; the next frame shifts them out.
            count_d = '0;
            tmo_d   = '0;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            clr_q     <= 1'b0;
            count_q   <= '0;
            tmo_q     <= '0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            clr_q     <= clr_d;
            count_q   <= count_d;
            tmo_q     <= tmo_d;
        end
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign rx_overrun = overrun_q;
    assign rx_clr     = clr_q;

    uart_tx_serializer #(
        .TX_BYTES (TX_BYTES)
    ) u_tx (
        .clock    (clock),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .tx_ready (tx_ready),
        .tx_done  (tx_done),
        .tx_byte  (tx_byte),
        .tx_wr_en (tx_wr_en)
    );

endmodule

// File: tb/tb_uart_word_framer.sv
// Bench for uart_word_framer: per-cycle behavioural model plus directed vectors.
module tb_uart_word_framer;

    localparam int unsigned RXB = 4;
    localparam int unsigned TXB = 4;
    localparam int unsigned TO  = 100;
    localparam int unsigned BUSY_LEN = 20;

    logic          clock, reset;
    logic [7:0]    rx_byte;
    logic          rx_rdy, rx_clr, rx_valid, rx_ack, rx_overrun;
    logic [31:0]   rx_data, tx_data;
    logic          tx_start, tx_ready, tx_done, tx_wr_en, tx_busy;
    logic [7:0]    tx_byte;
    logic          busy_hold, uart_busy;

    assign tx_busy = busy_hold | uart_busy;

    uart_word_framer #(
        .RX_BYTES       (RXB),
        .TX_BYTES       (TXB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rx_byte    (rx_byte),
        .rx_rdy     (rx_rdy),
        .rx_clr     (rx_clr),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ack     (rx_ack),
        .rx_overrun (rx_overrun),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .tx_byte    (tx_byte),
        .tx_wr_en   (tx_wr_en),
        .tx_busy    (tx_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int clr_count = 0;
    int wr_count = 0;
    int done_count = 0;
    logic [7:0] tx_log[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // UART transmitter: busy for BUSY_LEN cycles after each accepted write.
    initial begin
        int cnt;
        cnt = 0;
        uart_busy = 1'b0;
        forever begin
            @(negedge clock);
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) uart_busy = 1'b0;
            end else if (tx_wr_en === 1'b1) begin
                cnt = BUSY_LEN;
                uart_busy = 1'b1;
            end
        end
    end

    // Behavioural model state
    logic [31:0] m_data;
    bit          m_valid, m_ovr, m_clr;
    int          m_nb, m_idle;
    int          m_phase;          // 0 idle, 1 need write, 2 await busy rise, 3 await busy fall
    logic [7:0]  m_q[$];
    bit          m_wr, m_done;
    logic [7:0]  m_txb;

    logic        s_rst, s_rdy, s_ack, s_start, s_busy;
    logic [7:0]  s_byte;
    logic [31:0] s_txd;

    task automatic model_step();
        bit acc;
        if (s_rst) begin
            m_data = '0; m_valid = 0; m_ovr = 0; m_clr = 0; m_nb = 0; m_idle = 0;
            m_phase = 0; m_q.delete(); m_wr = 0; m_done = 0; m_txb = '0;
            return;
        end
        acc = s_rdy && !m_clr;
        if (s_ack && m_valid) begin
            m_valid = 0;
            m_ovr = 0;
        end
        if (acc) begin
            m_idle = 0;
            if (m_valid) m_ovr = 1;
            else begin
                m_data = {m_data[23:0], s_byte};
                m_nb++;
                if (m_nb == RXB) begin
                    m_valid = 1;
                    m_nb = 0;
                end
            end
        end else if (m_nb > 0 && !m_valid) begin
            m_idle++;
            if (m_idle == TO) begin
                m_nb = 0;
                m_idle = 0;
            end
        end
        m_clr = acc;

        m_wr = 0;
        m_done = 0;
        case (m_phase)
            0: if (s_start) begin
                for (int i = 0; i < TXB; i++) m_q.push_back(s_txd[31 - 8*i -: 8]);
                m_phase = 1;
            end
            1: if (!s_busy) begin
                m_txb = m_q.pop_front();
                m_wr = 1;
                m_phase = 2;
            end
            2: if (s_busy) m_phase = 3;
            default: if (!s_busy) begin
                if (m_q.size() == 0) begin
                    m_phase = 0;
                    m_done = 1;
                end else m_phase = 1;
            end
        endcase
    endtask

    // Compare process: every cycle, 1 time unit after the active edge.
    initial begin
        bit prev_wr;
        prev_wr = 0;
        forever begin
            @(posedge clock);
            s_rst = reset; s_rdy = rx_rdy; s_byte = rx_byte; s_ack = rx_ack;
            s_start = tx_start; s_txd = tx_data; s_busy = tx_busy;
            model_step();
            #1;
            chk("rx_clr", rx_clr, m_clr);
            chk("rx_valid", rx_valid, m_valid);
            chk("rx_overrun", rx_overrun, m_ovr);
            chk("rx_data", rx_data, m_data);
            chk("tx_ready", tx_ready, m_phase == 0);
            chk("tx_wr_en", tx_wr_en, m_wr);
            chk("tx_done", tx_done, m_done);
            chk("tx_byte", tx_byte, m_txb);
            if (tx_wr_en === 1'b1) begin
                chk("wr_en_with_busy", s_busy, 1'b0);
                chk("wr_en_back_to_back", prev_wr, 1'b0);
                tx_log.push_back(tx_byte);
                wr_count++;
            end
            if (tx_done === 1'b1) done_count++;
            if (rx_clr === 1'b1) clr_count++;
            prev_wr = (tx_wr_en === 1'b1);
        end
    end

    // Holds rdy through the clear cycle, as the real UART does.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        rx_byte = b;
        rx_rdy = 1'b1;
        @(negedge clock);
        @(negedge clock);
        rx_rdy = 1'b0;
    endtask

    task automatic ack_frame();
        @(negedge clock);
        rx_ack = 1'b1;
        @(negedge clock);
        rx_ack = 1'b0;
    endtask

    task automatic wait_wr(input int target, input int budget);
        for (int i = 0; i < budget && wr_count < target; i++) @(negedge clock);
        chk("wait_wr_count", wr_count, target);
    endtask

    initial begin
        int clr0, wr0, done0;
        reset = 1'b1; rx_byte = '0; rx_rdy = 0; rx_ack = 0;
        tx_data = '0; tx_start = 0; busy_hold = 0;
        repeat (3) @(negedge clock);
        chk("reset_rx_valid", rx_valid, 1'b0);
        chk("reset_rx_data", rx_data, 32'h0);
        chk("reset_tx_ready", tx_ready, 1'b1);
        reset = 1'b0;

        // Frame assembly
        clr0 = clr_count;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        chk("frame_data", rx_data, 32'h11223344);
        chk("frame_valid", rx_valid, 1'b1);
        chk("frame_clr_pulses", clr_count - clr0, 4);

        // Overrun while valid, then ack
        send_byte(8'h55);
        chk("overrun_data_frozen", rx_data, 32'h11223344);
        chk("overrun_flag", rx_overrun, 1'b1);
        ack_frame();
        chk("ack_clears_valid", rx_valid, 1'b0);
        chk("ack_clears_overrun", rx_overrun, 1'b0);

        // Timeout discards the lone 0xAA
        send_byte(8'hAA);
        repeat (TO) @(negedge clock);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        chk("timeout_not_yet_valid", rx_valid, 1'b0);
        send_byte(8'h04);
        chk("timeout_data", rx_data, 32'h01020304);
        chk("timeout_valid", rx_valid, 1'b1);

        // Ack and byte in the same cycle
        @(negedge clock);
        rx_ack = 1'b1; rx_byte = 8'h9A; rx_rdy = 1'b1;
        @(negedge clock);
        rx_ack = 1'b0;
        chk("ackbyte_valid", rx_valid, 1'b0);
        chk("ackbyte_overrun", rx_overrun, 1'b0);
        chk("ackbyte_data", rx_data, 32'h0203049A);
        @(negedge clock);
        rx_rdy = 1'b0;
        send_byte(8'hBC); send_byte(8'hDE); send_byte(8'hF0);
        chk("ackbyte_frame", rx_data, 32'h9ABCDEF0);
        chk("ackbyte_frame_valid", rx_valid, 1'b1);
        ack_frame();

        // Transmit with ignored mid-transmission start
        tx_log.delete();
        done0 = done_count;
        @(negedge clock);
        tx_data = 32'h12345678; tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
        chk("tx_ready_low", tx_ready, 1'b0);
        repeat (5) @(negedge clock);
        tx_data = 32'hDEADBEEF; tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
        for (int i = 0; i < 500 && done_count == done0; i++) @(negedge clock);
        chk("tx_done_count", done_count - done0, 1);
        chk("tx_log_len", tx_log.size(), 4);
        if (tx_log.size() == 4) begin
            chk("tx_byte0", tx_log[0], 8'h12);
            chk("tx_byte1", tx_log[1], 8'h34);
            chk("tx_byte2", tx_log[2], 8'h56);
            chk("tx_byte3", tx_log[3], 8'h78);
        end
        repeat (5) @(negedge clock);
        chk("tx_no_second_word", done_count - done0, 1);

        // Busy at start, then reset mid-send
        tx_log.delete();
        wr0 = wr_count;
        done0 = done_count;
        @(negedge clock);
        busy_hold = 1'b1; tx_data = 32'hA1B2C3D4; tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
        repeat (10) @(negedge clock);
        chk("no_wr_while_busy", wr_count, wr0);
        busy_hold = 1'b0;
        wait_wr(wr0 + 2, 200);
        repeat (5) @(negedge clock);
        if (tx_log.size() >= 2) begin
            chk("busy_byte0", tx_log[0], 8'hA1);
            chk("busy_byte1", tx_log[1], 8'hB2);
        end
        reset = 1'b1;
        @(negedge clock);
        chk("rst_tx_ready", tx_ready, 1'b1);
        chk("rst_tx_wr_en", tx_wr_en, 1'b0);
        chk("rst_tx_done", tx_done, 1'b0);
        chk("rst_tx_byte", tx_byte, 8'h00);
        chk("rst_rx_data", rx_data, 32'h0);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        chk("rst_no_done", done_count, done0);
        chk("rst_no_more_wr", wr_count, wr0 + 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
